// File: rtl/rv16_mul_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier sequencer.
package rv16_mul_pkg;

    localparam int unsigned DATA       = 16;
    localparam int unsigned MUL_CYCLES = DATA;
    localparam int unsigned CNT_W      = $clog2(DATA);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/rv16_mul_ctrl.sv
// Shift-and-add 16x16 unsigned multiply sequencer. The adder is external and
// driven through the add_* ports so it can later be shared with the ALU.
module rv16_mul_ctrl
    import rv16_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA-1:0]   op_a,
    input  logic [DATA-1:0]   op_b,
    output logic              busy,
    output logic              done,
    output logic [2*DATA-1:0] product,
    output logic [DATA-1:0]   add_a,
    output logic [DATA-1:0]   add_b,
    output logic              add_cin,
    input  logic [DATA-1:0]   add_sum,
    input  logic              add_cout
);

    mul_state_t        state;
    mul_state_t        state_nxt;
    logic [DATA-1:0]   m;
    logic [DATA-1:0]   hi;
    logic [DATA-1:0]   lo;
    logic [CNT_W-1:0]  cnt;
    logic              last_step;

    assign last_step = (cnt == CNT_W'(MUL_CYCLES - 1));

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = {hi, lo};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; abort takes priority over completing the run.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (abort)          state_nxt = IDLE;
                else if (last_step) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Adder operands; held at zero outside RUN to keep the shared adder quiet.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a = hi;
            add_b = lo[0] ? m : '0;
        end
    end

    // Datapath: load on accept, then one add/shift step per RUN cycle.
    // The carry-out re-enters at the top of HI, so the accumulator never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m   <= '0;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= op_a;
                        hi  <= '0;
                        lo  <= op_b;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        hi <= '0;
                        lo <= '0;
                    end else begin
                        hi  <= {add_cout, add_sum[DATA-1:1]};
                        lo  <= {add_sum[0], lo[DATA-1:1]};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
